// File: rtl/vga_timing_gen_if.sv
// vga_if: VGA sync and colour bundle shared by the timing generators and the screen mux
interface vga_if #(
    parameter int COLOR_W = 4
);
    logic               hs;
    logic               vs;
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;
    modport src (output hs, vs, red, green, blue);
    modport snk (input hs, vs, red, green, blue);
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing with pixel-coordinate requests and latency-aligned RGB output
module vga_timing_gen #(
    parameter int COLOR_W  = 4,
    parameter int H_ACT    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACT    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PIPE_LAT = 2,
    parameter int X_W      = $clog2(H_ACT + H_FP + H_SYNC + H_BP),
    parameter int Y_W      = $clog2(V_ACT + V_FP + V_SYNC + V_BP)
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               en_i,
    output logic [X_W-1:0]     pix_x_o,
    output logic [Y_W-1:0]     pix_y_o,
    output logic               pix_req_o,
    output logic               frame_start_o,
    input  logic [COLOR_W-1:0] red_i,
    input  logic [COLOR_W-1:0] green_i,
    input  logic [COLOR_W-1:0] blue_i,
    vga_if.src                 vga_out_if
);
    localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
    localparam logic [X_W-1:0] H_LAST = X_W'(H_TOT - 1);
    localparam logic [X_W-1:0] H_ACT_C = X_W'(H_ACT);
    localparam logic [X_W-1:0] HS_BEG = X_W'(H_ACT + H_FP);
    localparam logic [X_W-1:0] HS_END = X_W'(H_ACT + H_FP + H_SYNC);
    localparam logic [Y_W-1:0] V_LAST = Y_W'(V_TOT - 1);
    localparam logic [Y_W-1:0] V_ACT_C = Y_W'(V_ACT);
    localparam logic [Y_W-1:0] VS_BEG = Y_W'(V_ACT + V_FP);
    localparam logic [Y_W-1:0] VS_END = Y_W'(V_ACT + V_FP + V_SYNC);

    logic [X_W-1:0]     h_cnt;
    logic [Y_W-1:0]     v_cnt;
    logic               h_wrap;
    logic [2:0]         ctl_raw;
    logic [2:0]         ctl_q;
    logic [2:0]         ctl_d;
    logic               hs_q;
    logic               vs_q;
    logic [COLOR_W-1:0] red_q;
    logic [COLOR_W-1:0] green_q;
    logic [COLOR_W-1:0] blue_q;

    assign h_wrap = h_cnt == H_LAST;
    // control word layout: {pix_req, vs_active, hs_active}
    assign ctl_raw = {(h_cnt < H_ACT_C) && (v_cnt < V_ACT_C),
                      (v_cnt >= VS_BEG) && (v_cnt < VS_END),
                      (h_cnt >= HS_BEG) && (h_cnt < HS_END)};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            h_cnt         <= '0;
            v_cnt         <= '0;
            pix_x_o       <= '0;
            pix_y_o       <= '0;
            ctl_q         <= '0;
            frame_start_o <= 1'b0;
        end else if (!en_i) begin
            h_cnt         <= '0;
            v_cnt         <= '0;
            pix_x_o       <= '0;
            pix_y_o       <= '0;
            ctl_q         <= '0;
            frame_start_o <= 1'b0;
        end else begin
            h_cnt         <= h_wrap ? '0 : h_cnt + X_W'(1);
            if (h_wrap)
                v_cnt     <= (v_cnt == V_LAST) ? '0 : v_cnt + Y_W'(1);
            pix_x_o       <= h_cnt;
            pix_y_o       <= v_cnt;
            ctl_q         <= ctl_raw;
            frame_start_o <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

    assign pix_req_o = ctl_q[2];

    // controls wait PIPE_LAT cycles so they meet the source's returned colour
    generate
        if (PIPE_LAT == 0) begin : g_nodly
            assign ctl_d = ctl_q;
        end else begin : g_dly
            logic [2:0] sr [PIPE_LAT];
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    for (int i = 0; i < PIPE_LAT; i++) sr[i] <= '0;
                end else if (!en_i) begin
                    for (int i = 0; i < PIPE_LAT; i++) sr[i] <= '0;
                end else begin
                    sr[0] <= ctl_q;
                    for (int i = 1; i < PIPE_LAT; i++) sr[i] <= sr[i-1];
                end
            end
            assign ctl_d = sr[PIPE_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else if (!en_i) begin
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else begin
            hs_q    <= ctl_d[0] ? HS_POL : ~HS_POL;
            vs_q    <= ctl_d[1] ? VS_POL : ~VS_POL;
            red_q   <= ctl_d[2] ? red_i : '0;
            green_q <= ctl_d[2] ? green_i : '0;
            blue_q  <= ctl_d[2] ? blue_i : '0;
        end
    end

    assign vga_out_if.hs    = hs_q;
    assign vga_out_if.vs    = vs_q;
    assign vga_out_if.red   = red_q;
    assign vga_out_if.green = green_q;
    assign vga_out_if.blue  = blue_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of raster timing, alignment, enable and async reset
`timescale 1ns/1ps
module tb_vga_timing_gen;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [9:0] x_a, y_a, x_b;
    logic [2:0] y_b;
    logic       req_a, fs_a, req_b, fs_b;
    logic [3:0] r1 = '0, r2 = '0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    // source with 2-cycle latency returning red = pix_x[3:0]
    always @(posedge clk) begin
        r1 <= x_a[3:0];
        r2 <= r1;
    end

    vga_if #(.COLOR_W(4)) va ();
    vga_if #(.COLOR_W(4)) vb ();

    vga_timing_gen dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en),
        .pix_x_o(x_a), .pix_y_o(y_a), .pix_req_o(req_a), .frame_start_o(fs_a),
        .red_i(r2), .green_i(4'hF), .blue_i(4'hF), .vga_out_if(va)
    );

    vga_timing_gen #(
        .PIPE_LAT(0), .HS_POL(1'b1), .VS_POL(1'b1),
        .V_ACT(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en),
        .pix_x_o(x_b), .pix_y_o(y_b), .pix_req_o(req_b), .frame_start_o(fs_b),
        .red_i(x_b[3:0]), .green_i(4'hF), .blue_i(4'hF), .vga_out_if(vb)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        int p, hfa0, hfa1, hs_lo_a, vs_lo_a, fs_cnt_a, red_bad_a, gf, gl;
        int grn_a [2];
        int hfb, hs_hi_b, vs_hi_b, vsb_first, fs_cnt_b, fs_last_b, red_bad_b, grn_b, grn_b_out;
        int bad, found;
        logic hs_prev;
        hfa0 = -1; hfa1 = -1; hs_lo_a = 0; vs_lo_a = 0; fs_cnt_a = 0; red_bad_a = 0;
        gf = -1; gl = -1; grn_a[0] = 0; grn_a[1] = 0;
        hfb = -1; hs_hi_b = 0; vs_hi_b = 0; vsb_first = -1; fs_cnt_b = 0; fs_last_b = -1;
        red_bad_b = 0; grn_b = 0; grn_b_out = 0; hs_prev = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_hs_a", va.hs, 1);
        check("rst_vs_a", va.vs, 1);
        check("rst_red_a", va.red, 0);
        check("rst_req_a", req_a, 0);
        check("rst_fs_a", fs_a, 0);
        check("rst_x_a", x_a, 0);
        check("rst_hs_b", vb.hs, 0);
        check("rst_vs_b", vb.vs, 0);

        rst_n = 1'b1;
        en = 1'b1;
        for (int n = 1; n <= 6500; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check("first_fs_a", fs_a, 1);
                check("first_x_a", x_a, 0);
                check("first_y_a", y_a, 0);
                check("first_fs_b", fs_b, 1);
            end
            if (hs_prev && !va.hs) begin
                if (hfa0 < 0) hfa0 = n;
                else if (hfa1 < 0) hfa1 = n;
            end
            hs_prev = va.hs;
            if (n <= 800 && !va.hs) hs_lo_a++;
            if (!va.vs) vs_lo_a++;
            if (fs_a) fs_cnt_a++;
            p = n - 4;
            if (p >= 0 && p < 1600) begin
                if (p < 800 && int'(va.red) != ((p < 640) ? p % 16 : 0)) red_bad_a++;
                if (va.green == 4'hF) begin
                    grn_a[p/800]++;
                    if (p < 800) begin
                        if (gf < 0) gf = p;
                        gl = p;
                    end
                end
            end
            p = n - 2;
            if (fs_b) begin
                fs_cnt_b++;
                fs_last_b = n;
            end
            if (vb.hs && hfb < 0) hfb = n;
            if (n <= 800 && vb.hs) hs_hi_b++;
            if (vb.vs) begin
                vs_hi_b++;
                if (vsb_first < 0) vsb_first = n;
            end
            if (p >= 0 && p < 800 && int'(vb.red) != ((p < 640) ? p % 16 : 0)) red_bad_b++;
            if (p >= 0 && p < 6400 && vb.green == 4'hF) begin
                grn_b++;
                if (p >= 3200) grn_b_out++;
            end
        end
        check("hs_fall_delay_a", hfa0 - 1, 659);
        check("hs_period_a", hfa1 - hfa0, 800);
        check("hs_low_len_a", hs_lo_a, 96);
        check("vs_low_early_a", vs_lo_a, 0);
        check("fs_count_a", fs_cnt_a, 1);
        check("red_bad_a", red_bad_a, 0);
        check("active_line0_a", grn_a[0], 640);
        check("active_line1_a", grn_a[1], 640);
        check("active_first_a", gf, 0);
        check("active_last_a", gl, 639);
        check("hs_rise_delay_b", hfb - 1, 657);
        check("hs_high_len_b", hs_hi_b, 96);
        check("red_bad_b", red_bad_b, 0);
        check("vs_high_len_b", vs_hi_b, 1600);
        check("vs_start_b", vsb_first - 1, 4001);
        check("fs_count_b", fs_cnt_b, 2);
        check("fs_period_b", fs_last_b - 1, 6400);
        check("window_px_b", grn_b, 2560);
        check("blank_rows_b", grn_b_out, 0);

        found = 0;
        for (int i = 0; i < 20000; i++) begin
            if (x_a == 10'd299 && y_a == 10'd10) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("reach_drop_pos", found, 1);
        check("pre_drop_green_a", va.green, 15);
        en = 1'b0;
        @(negedge clk);
        check("dis_hs_a", va.hs, 1);
        check("dis_vs_a", va.vs, 1);
        check("dis_green_a", va.green, 0);
        check("dis_req_a", req_a, 0);
        check("dis_x_a", x_a, 0);
        check("dis_green_b", vb.green, 0);
        bad = 0;
        repeat (49) begin
            @(negedge clk);
            if (!va.hs || !va.vs || va.green != 0 || va.red != 0 || req_a || fs_a) bad++;
        end
        check("dis_hold_a", bad, 0);
        en = 1'b1;
        @(negedge clk);
        check("reen_fs_a", fs_a, 1);
        check("reen_x_a", x_a, 0);
        check("reen_y_a", y_a, 0);
        @(negedge clk);
        check("reen_fs_off_a", fs_a, 0);
        check("reen_x1_a", x_a, 1);

        repeat (150) @(negedge clk);
        check("pre_rst_green_a", va.green, 15);
        #1 rst_n = 1'b0;
        #1;
        check("arst_green_a", va.green, 0);
        check("arst_hs_a", va.hs, 1);
        check("arst_req_a", req_a, 0);
        check("arst_x_a", x_a, 0);
        check("arst_green_b", vb.green, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_fs_a", fs_a, 1);
        check("post_rst_x_a", x_a, 0);
        check("post_rst_y_a", y_a, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
